spi_master_param: RTL
=====================

Name: spi_master_param

Overview:
Parameterised SPI master that runs one full-duplex transfer per req_i/ack_o handshake. The word width, serial clock divider, chip-select count and inter-transfer gap are set by parameters. All four SPI modes (CPOL/CPHA) are selectable per transfer. It sits between sensor-polling control logic and off-chip SPI peripherals on the DE10-Lite, with one chip-select line per device.

Parameters:
DATA_W, 16, bits per transfer (2..32)
CS_NUM, 2, number of chip-select lines (1..8)
CS_W, 1, width of cs_sel_i (>= clog2(CS_NUM), min 1)
CLK_DIV, 4, clk_i cycles per SCLK half-period (>= 1)
GAP_CYCLES, 100000, minimum clk_i cycles with all CS high between transfers (>= 1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
req_i  in  1  transfer request (level); accepted only in IDLE
ack_o  out  1  one-cycle pulse when transfer done and rx_data_o valid
busy_o  out  1  high from LEAD through GAP
mode_i  in  2  {CPOL,CPHA}; latched at accept
cs_sel_i  in  CS_W  target chip-select index; latched at accept
tx_data_i  in  DATA_W  word to send, MSB first; latched at accept
rx_data_o  out  DATA_W  last received word; holds until next ack_o
spi_sclk_o  out  1  serial clock
spi_mosi_o  out  1  master out
spi_miso_i  in  1  master in
spi_cs_n_o  out  CS_NUM  active-low chip selects

Behaviour:
- Reset (async, immediate, also mid-transfer):
  - ack_o=0, busy_o=0, rx_data_o=0, spi_mosi_o=0.
  - spi_cs_n_o all 1, latched mode=0, so spi_sclk_o=0.
  - State IDLE; all counters 0.
- States: IDLE -> LEAD -> SHIFT -> TRAIL -> ACK -> GAP -> IDLE.
- IDLE:
  - CS all high; sclk at latched CPOL.
  - req_i=1 on edge E0 latches mode/cs/tx and enters LEAD.
- LEAD (CLK_DIV cycles):
  - spi_cs_n_o[cs_sel] low; sclk=CPOL.
  - CPHA=0: mosi = tx MSB from the LEAD entry cycle.
- SHIFT (2*DATA_W*CLK_DIV cycles):
  - A half-period tick occurs every CLK_DIV cycles; each tick toggles sclk, for 2*DATA_W edges in total.
  - CPHA=0: sample miso on odd (leading) edges; shift next mosi bit on even (trailing) edges, except the last edge.
  - CPHA=1: drive mosi bit on leading edges; sample on trailing edges.
  - Sampled bits shift into rx shift register LSB-side, so the first sampled bit ends at the MSB.
- TRAIL (CLK_DIV cycles): CS held low; sclk=CPOL.
- ACK (1 cycle):
  - CS all high; ack_o=1; rx_data_o loaded from shift register in the same cycle.
- GAP (GAP_CYCLES cycles): CS high, busy_o=1, req_i ignored.
- Latency: ack_o high in the cycle beginning at E0 + (2*DATA_W+2)*CLK_DIV clk_i cycles.
- req_i held high continuously: next transfer accepted on the first IDLE cycle after GAP.
- Input changes:
  - mode_i/cs_sel_i/tx_data_i changes after accept have no effect on the current transfer.
  - A request dropped mid-transfer does not abort.
- cs_sel_i >= CS_NUM: no CS asserted, transfer and ack_o still occur, and rx_data_o reflects miso as sampled.
- mode change between transfers: sclk moves to the new CPOL in the LEAD entry cycle while CS is still high for one cycle. The first CS-low cycle is E0+1.
- Only one CS line is ever low at a time.

Optional Feature:
SPI_LOOPBACK_EN:
- Defined: adds input loopback_i (1 bit). When loopback_i=1, the sampling logic uses the internal mosi value instead of spi_miso_i, so rx_data_o == tx word. CS/sclk/mosi pins behave normally.
- Undefined: no port; sampling always uses spi_miso_i.

Test Plan:
- Mode 0 transfer, DATA_W=16, CLK_DIV=4, GAP_CYCLES=8, tx=0xA55A, slave model drives 0x3C0F:
  - mosi bits 1010_0101_0101_1010 seen on rising edges;
  - rx_data_o=0x3C0F;
  - ack_o at E0+136;
  - 16 rising sclk edges.
- Mode 3 transfer, tx=0x8001, slave 0xFFFE:
  - sclk idles 1, samples taken on rising edges;
  - rx=0xFFFE;
  - sclk=1 after TRAIL.
- req_i held high for 3 transfers:
  - 3 ack_o pulses;
  - CS high >= 9 cycles (ACK + GAP) between each CS-low window;
  - busy_o never drops between LEAD and GAP.
- cs_sel=1 gives only spi_cs_n_o[1] low; cs_sel=3 with CS_NUM=2 gives no CS low, ack_o still at E0+136.
- rst_i asserted mid-SHIFT (edge 10):
  - CS all 1, sclk 0, ack_o 0, rx_data_o 0 immediately;
  - after release, a mode 1 transfer with tx=0x1234 completes correctly.
- SPI_LOOPBACK_EN defined, loopback_i=1, tx=0x5AC3, miso tied 0 gives rx_data_o=0x5AC3; loopback_i=0 gives 0x0000.

Source files
------------

// File: rtl/spi_master_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_param_if
//  Description : Bundles the request/acknowledge handshake, the transfer
//                data/config and the SPI pins of spi_master_param.
//                master modport : seen by the SPI master (the DUT)
//                slave  modport : seen by the controlling logic / bench
//  Signals     : req_i, ack_o, busy_o, mode_i[1:0], cs_sel_i[CS_W-1:0],
//                tx_data_i[DATA_W-1:0], rx_data_o[DATA_W-1:0],
//                spi_sclk_o, spi_mosi_o, spi_miso_i, spi_cs_n_o[CS_NUM-1:0]
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_master_param_if #(
    parameter int DATA_W = 16,
    parameter int CS_NUM = 2,
    parameter int CS_W   = 1
);
    logic                req_i;
    logic                ack_o;
    logic                busy_o;
    logic [1:0]          mode_i;
    logic [CS_W-1:0]     cs_sel_i;
    logic [DATA_W-1:0]   tx_data_i;
    logic [DATA_W-1:0]   rx_data_o;
    logic                spi_sclk_o;
    logic                spi_mosi_o;
    logic                spi_miso_i;
    logic [CS_NUM-1:0]   spi_cs_n_o;

    modport master (
        input  req_i, mode_i, cs_sel_i, tx_data_i, spi_miso_i,
        output ack_o, busy_o, rx_data_o, spi_sclk_o, spi_mosi_o, spi_cs_n_o
    );

    modport slave (
        output req_i, mode_i, cs_sel_i, tx_data_i, spi_miso_i,
        input  ack_o, busy_o, rx_data_o, spi_sclk_o, spi_mosi_o, spi_cs_n_o
    );
endinterface
`default_nettype wire

// File: rtl/spi_master_param.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_param
//  Description : Parameterised full-duplex SPI master. One transfer per
//                req_i/ack_o handshake, all four CPOL/CPHA modes selectable
//                per transfer, one active-low chip select per peripheral and
//                an enforced idle gap between transfers.
//  Ports       : clk_i  - system clock
//                rst_i  - asynchronous active-high reset
//                bus    - spi_master_param_if.master (handshake, data, pins)
//                loopback_i - (SPI_LOOPBACK_EN only) sample internal mosi
//                             instead of spi_miso_i
//  Options     : `define SPI_LOOPBACK_EN adds the loopback_i port.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_param #(
    parameter int DATA_W     = 16,
    parameter int CS_NUM     = 2,
    parameter int CS_W       = 1,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 100000
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    spi_master_param_if.master bus
`ifdef SPI_LOOPBACK_EN
    ,
    input  wire logic          loopback_i
`endif
);

    // One counter serves LEAD/SHIFT/TRAIL (half-period) and GAP timing.
    localparam int C_CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);
    localparam int C_EDGE_W  = $clog2(2 * DATA_W + 1);

    localparam logic [C_CNT_W-1:0]  C_DIV_LAST = C_CNT_W'(CLK_DIV - 1);
    localparam logic [C_CNT_W-1:0]  C_GAP_LAST = C_CNT_W'(GAP_CYCLES - 1);
    localparam logic [C_EDGE_W-1:0] C_EDGES    = C_EDGE_W'(2 * DATA_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_ACK   = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t              r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [C_EDGE_W-1:0] r_edge;
    logic                r_cpha;
    logic [CS_W-1:0]     r_cs_sel;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   r_rx_data;
    logic                r_ack;
    logic                r_busy;
    logic                r_sclk;
    logic                r_mosi;
    logic [CS_NUM-1:0]   r_cs_n;

    logic [C_EDGE_W-1:0] w_edge_nxt;
    logic                w_leading;
    logic                w_sample;
    logic                w_drive;
    logic                w_miso;
    logic [CS_NUM-1:0]   w_cs_dec;

    // Number of the sclk edge produced by the current tick (1..2*DATA_W);
    // odd numbers are the leading edges of each sclk period.
    assign w_edge_nxt = r_edge + C_EDGE_W'(1);
    assign w_leading  = w_edge_nxt[0];
    assign w_sample   = r_cpha ? ~w_leading : w_leading;
    // CPHA=0 already presented the MSB before the first edge, so the final
    // trailing edge has no bit left to shift out.
    assign w_drive    = r_cpha ? w_leading
                               : (~w_leading && (w_edge_nxt != C_EDGES));

`ifdef SPI_LOOPBACK_EN
    assign w_miso = loopback_i ? r_mosi : bus.spi_miso_i;
`else
    assign w_miso = bus.spi_miso_i;
`endif

    // Out-of-range selects decode to no active line.
    always_comb begin
        w_cs_dec = '0;
        for (int i = 0; i < CS_NUM; i++) begin
            if (32'(r_cs_sel) == i) begin
                w_cs_dec[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_edge    <= '0;
            r_cpha    <= 1'b0;
            r_cs_sel  <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= '1;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cs_n <= '1;
                    if (bus.req_i) begin
                        r_cpha   <= bus.mode_i[0];
                        r_cs_sel <= bus.cs_sel_i;
                        // sclk takes the new CPOL now; CS follows a cycle later.
                        r_sclk   <= bus.mode_i[1];
                        if (!bus.mode_i[0]) begin
                            r_mosi <= bus.tx_data_i[DATA_W-1];
                            r_tx   <= {bus.tx_data_i[DATA_W-2:0], 1'b0};
                        end else begin
                            r_tx   <= bus.tx_data_i;
                        end
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LEAD;
                    end
                end

                S_LEAD: begin
                    r_cs_n <= ~w_cs_dec;
                    if (r_cnt == C_DIV_LAST) begin
                        r_cnt   <= '0;
                        r_edge  <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (r_cnt == C_DIV_LAST) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        r_edge <= w_edge_nxt;
                        // miso is captured at the same clk edge that moves
                        // sclk, i.e. the value the slave held for the
                        // preceding half period.
                        if (w_sample) begin
                            r_rx <= {r_rx[DATA_W-2:0], w_miso};
                        end
                        if (w_drive) begin
                            r_mosi <= r_tx[DATA_W-1];
                            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
                        end
                        if (w_edge_nxt == C_EDGES) begin
                            r_state <= S_TRAIL;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end

                S_TRAIL: begin
                    if (r_cnt == C_DIV_LAST) begin
                        r_cnt     <= '0;
                        r_cs_n    <= '1;
                        r_ack     <= 1'b1;
                        r_rx_data <= r_rx;
                        r_state   <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end

                S_ACK: begin
                    r_cnt   <= '0;
                    r_state <= S_GAP;
                end

                S_GAP: begin
                    if (r_cnt == C_GAP_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end

                default: begin
                    r_cs_n  <= '1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o      = r_ack;
    assign bus.busy_o     = r_busy;
    assign bus.rx_data_o  = r_rx_data;
    assign bus.spi_sclk_o = r_sclk;
    assign bus.spi_mosi_o = r_mosi;
    assign bus.spi_cs_n_o = r_cs_n;

endmodule
`default_nettype wire
